fpu_div_arbiter: RTL
====================

// Module: fpu_div_arbiter
// PURPOSE
//   Shares one combinational fpu_sp_divider between NUM_REQ requesters.
//   - Round-robin grant; operands registered and held while the divider settles.
//   - Quotient is registered and returned with the requester ID over a valid/ready response port.
//   - Sits between issue logic and the single-precision FPU datapath.
// PARAMETERS
//   NUM_REQ        4   number of requesters (2..16)
//   WIDTH          32  operand/result width (IEEE-754 single)
//   SETTLE_CYCLES  2   cycles the divider is allowed to settle before capture (>=1)
// PORTS
//   clk          in   1              clock, all state on rising edge
//   rst          in   1              asynchronous reset, active-high
//   req_valid    in   NUM_REQ        per-requester operation request
//   req_ready    out  NUM_REQ        one-hot grant/accept
//   req_a        in   NUM_REQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   NUM_REQ*WIDTH  divisors, same packing
//   rsp_valid    out  1              quotient available
//   rsp_ready    in   1              consumer accepts quotient
//   rsp_result   out  WIDTH          quotient A/B from fpu_sp_divider
//   rsp_id       out  $clog2(NUM_REQ) index of requester that issued the op
//   busy         out  1              high in any state other than IDLE
// BEHAVIOUR
//   Reset values:
//   - Reset (async, any state) -> IDLE; rr_ptr=0; counter=0.
//   - All outputs 0: rsp_valid, rsp_result, rsp_id, req_ready, busy.
//   - An in-flight op is discarded, never reported.
//   FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE:
//   - grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   - req_ready[g]=1 combinationally; all other req_ready bits 0.
//   - On req_valid[g]&&req_ready[g], the handshake takes one cycle:
//     * register op_a/op_b from slot g; id<=g.
//     * counter<=SETTLE_CYCLES-1; go to WAIT.
//   - No request -> stay IDLE; rr_ptr unchanged.
//   WAIT:
//   - op registers drive the divider; req_ready all 0.
//   - counter decrements each cycle.
//   - When counter==0: rsp_result<=divider output; rsp_valid<=1; go to RESP.
//   RESP:
//   - Hold rsp_result/rsp_id/rsp_valid stable until rsp_ready.
//   - On handshake: rsp_valid<=0; rr_ptr<=(id+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0); go to IDLE.
//   Timing:
//   - Latency: accept at edge T -> rsp_valid high after edge T+SETTLE_CYCLES.
//   - Minimum issue interval: SETTLE_CYCLES+2 cycles (IDLE is always one full cycle).
//   Boundary conditions:
//   - A requester dropping req_valid before grant has no effect.
//   - Inputs changing in WAIT/RESP are ignored (operands already registered).
//   - rsp_ready held high: RESP lasts exactly one cycle.
//   - All NUM_REQ valid: each is served once before any repeat (no starvation).
//   - No arithmetic in this block; special values (NaN, Inf, 0) pass through from the divider unchanged.
// CONFIGURATION
//   FPU_DIV_EXC_EN defined:
//   - Adds outputs rsp_dbz (1b) and rsp_nan (1b), captured with rsp_result, reset 0.
//   - rsp_dbz=1 when op_b is +/-0 and op_a is finite non-zero.
//   - rsp_nan=1 when either operand is NaN, 0/0, or Inf/Inf.
//   FPU_DIV_EXC_EN undefined:
//   - Ports and logic absent; behaviour otherwise identical.
// TESTING
//   1. Single op, requester 0: A=0x40866666 (4.2), B=0x404CCCCD (3.2), rsp_ready=1
//      -> rsp_valid at T+SETTLE_CYCLES, rsp_result=0x3FA80000 (1.3125), rsp_id=0.
//   2. Sign handling, requester 2: -6.4/-0.5 -> 0x414CCCCD; 6.4/-0.5 -> 0xC14CCCCD.
//   3. Round-robin: all 4 req_valid held high with distinct operands
//      -> grants in order 0,1,2,3,0; every rsp_id matches its quotient.
//   4. Backpressure: rsp_ready=0 for 5 cycles in RESP
//      -> rsp_valid/result/id stable; req_ready stays 0; ops complete in order after release.
//   5. Reset mid-op: assert rst in WAIT
//      -> all outputs 0 immediately, no response emitted; next grant goes to requester 0.
//   6. FPU_DIV_EXC_EN: 1.0/0.0 -> rsp_dbz=1, rsp_nan=0; 0.0/0.0 -> rsp_nan=1.

Source files
------------

// File: rtl/fpu_div_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision divider between NUM_REQ requesters.
// Define FPU_DIV_EXC_EN to add the rsp_dbz/rsp_nan exception flag outputs.

module fpu_sp_divider (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  logic              sa, sb, sq;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [23:0]       ma, mb;
  logic [25:0]       quo;
  logic [24:0]       rem;
  logic [23:0]       mant, mant_n;
  logic              guard, sticky, carry;
  logic signed [9:0] exp_q;
  logic [22:0]       frac;

  // Subnormal operands are flushed to zero; tiny results flush to signed zero.
  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    sq     = sa ^ sb;
    a_nan  = (ea == 8'hff) && (fa != '0);
    b_nan  = (eb == 8'hff) && (fb != '0);
    a_inf  = (ea == 8'hff) && (fa == '0);
    b_inf  = (eb == 8'hff) && (fb == '0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    ma     = {1'b1, fa};
    mb     = {1'b1, fb};

    quo = '0;
    rem = {1'b0, ma};
    for (int i = 25; i >= 0; i--) begin
      if (rem >= {1'b0, mb}) begin
        quo[i] = 1'b1;
        rem    = rem - {1'b0, mb};
      end
      rem = rem << 1;
    end

    if (quo[25]) begin
      mant   = quo[25:2];
      guard  = quo[1];
      sticky = quo[0] | (rem != '0);
      exp_q  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    end else begin
      mant   = quo[24:1];
      guard  = quo[0];
      sticky = (rem != '0);
      exp_q  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
    end

    // Round to nearest even; a carry out renormalises to 1.0 at the next exponent.
    {carry, mant_n} = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
    frac = carry ? mant_n[23:1] : mant_n[22:0];
    if (carry) exp_q = exp_q + 10'sd1;

    q = {sq, exp_q[7:0], frac};
    if (exp_q >= 10'sd255)     q = {sq, 8'hff, 23'h0};
    else if (exp_q <= 10'sd0)  q = {sq, 31'h0};
    if (a_zero || b_inf)       q = {sq, 31'h0};
    if (a_inf || b_zero)       q = {sq, 8'hff, 23'h0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) q = 32'h7fc00000;
  end
endmodule

module fpu_div_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
`ifdef FPU_DIV_EXC_EN
  output logic                       rsp_dbz,
  output logic                       rsp_nan,
`endif
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    rr_ptr, id, grant;
  logic             gnt_found;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] op_a, op_b, div_q;

  fpu_sp_divider u_div (
    .a (op_a),
    .b (op_b),
    .q (div_q)
  );

  // Rotating-priority search starting at rr_ptr.
  always_comb begin
    int idx;
    grant     = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        grant     = IW'(idx);
        gnt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_found && !rst) begin
          req_ready[grant] = 1'b1;
          state_n          = WAIT;
        end
      end
      WAIT:    if (counter == '0) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign rsp_id = id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      counter    <= '0;
      id         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_result <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op_a    <= req_a[int'(grant)*WIDTH +: WIDTH];
            op_b    <= req_b[int'(grant)*WIDTH +: WIDTH];
            id      <= grant;
            counter <= CW'(SETTLE_CYCLES - 1);
          end
        end
        WAIT: begin
          if (counter == '0) begin
            rsp_result <= div_q;
            rsp_valid  <= 1'b1;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (id == IW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_DIV_EXC_EN
  logic a_zero_x, b_zero_x, a_nan_x, b_nan_x, a_inf_x, b_inf_x, exc_dbz, exc_nan;

  always_comb begin
    a_zero_x = (op_a[30:0] == '0);
    b_zero_x = (op_b[30:0] == '0);
    a_nan_x  = (op_a[30:23] == 8'hff) && (op_a[22:0] != '0);
    b_nan_x  = (op_b[30:23] == 8'hff) && (op_b[22:0] != '0);
    a_inf_x  = (op_a[30:23] == 8'hff) && (op_a[22:0] == '0);
    b_inf_x  = (op_b[30:23] == 8'hff) && (op_b[22:0] == '0);
    exc_dbz  = b_zero_x && !a_zero_x && (op_a[30:23] != 8'hff);
    exc_nan  = a_nan_x || b_nan_x || (a_zero_x && b_zero_x) || (a_inf_x && b_inf_x);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_dbz <= 1'b0;
      rsp_nan <= 1'b0;
    end else if (state == WAIT && counter == '0) begin
      rsp_dbz <= exc_dbz;
      rsp_nan <= exc_nan;
    end
  end
`else
`endif

endmodule
